// File: rtl/ssled_pkg.sv
// Shared constants and types for the seven-segment scan capture block.
package ssled_pkg;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_BLANK  = 4'hF;

  typedef enum logic [1:0] {
    SYNC,
    COLLECT,
    PUBLISH
  } state_t;

  typedef logic [1:0] digit_t;

  typedef struct packed {
    logic   legal;
    digit_t idx;
  } sel_t;

  // Only a single low enable selects a digit.
  function automatic sel_t an_sel(
    input logic [3:0] an
  );
    sel_t s;
    s = '{legal: 1'b1, idx: 2'd0};
    case (an)
      4'b1110: s.idx = 2'd0;
      4'b1101: s.idx = 2'd1;
      4'b1011: s.idx = 2'd2;
      4'b0111: s.idx = 2'd3;
      default: s.legal = 1'b0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ssled_if.sv
// Seven-segment display bus plus the recovered score outputs.
interface ssled_if;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] score;
  logic        score_valid;
  logic        frame_bad;
  logic        order_err;

  modport master (
    output seg,
    output an,
    input  score,
    input  score_valid,
    input  frame_bad,
    input  order_err
  );

  modport slave (
    input  seg,
    input  an,
    output score,
    output score_valid,
    output frame_bad,
    output order_err
  );
endinterface

// File: rtl/ssled_seg_decode.sv
// Active-low segment pattern to digit value; unknown patterns give F.
module ssled_seg_decode
  import ssled_pkg::*;
(
  input  logic [6:0] seg,
  output logic       valid,
  output logic [3:0] nibble
);

  always_comb begin
    valid  = 1'b1;
    nibble = 4'h0;
    case (seg)
      SEG_0:   nibble = 4'd0;
      SEG_1:   nibble = 4'd1;
      SEG_2:   nibble = 4'd2;
      SEG_3:   nibble = 4'd3;
      SEG_4:   nibble = 4'd4;
      SEG_5:   nibble = 4'd5;
      SEG_6:   nibble = 4'd6;
      SEG_7:   nibble = 4'd7;
      SEG_8:   nibble = 4'd8;
      SEG_9:   nibble = 4'd9;
      default: begin
        valid  = 1'b0;
        nibble = 4'hF;
      end
    endcase
  end

endmodule

// File: rtl/ssled_capture.sv
// Samples the multiplexed display bus, debounces each digit dwell and
// reassembles the 16-bit score once per complete scan frame.
module ssled_capture
  import ssled_pkg::*;
#(
  parameter int unsigned SETTLE = 4
) (
  input logic   clk,
  input logic   rst,
  ssled_if.slave bus
);

  localparam logic [7:0] SET = 8'(SETTLE);

  logic [10:0] s1;
  logic [10:0] s2;
  logic [7:0]  dwell;
  logic        armed;
  logic        capture;

  logic        seg_ok;
  logic [3:0]  nib;
  sel_t        sel;
  logic        blank;
  logic        first;

  state_t      state;
  digit_t      want;
  logic [15:0] frame;
  logic        bad;

  logic [15:0] score;
  logic        score_valid;
  logic        frame_bad;
  logic        order_err;

  // s2 holds the synchronized {seg, an} pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= {SEG_BLANK, AN_BLANK};
      s2    <= {SEG_BLANK, AN_BLANK};
      dwell <= '0;
      armed <= 1'b1;
    end else begin
      s1 <= {bus.seg, bus.an};
      s2 <= s1;
      if (s1 != s2) begin
        dwell <= 8'd1;
        armed <= 1'b1;
      end else begin
        if (dwell != SET)
          dwell <= dwell + 8'd1;
        if (capture)
          armed <= 1'b0;
      end
    end
  end

  assign capture = armed && (dwell == SET);

  ssled_seg_decode u_dec (
    .seg    (s2[10:4]),
    .valid  (seg_ok),
    .nibble (nib)
  );

  assign sel   = an_sel(s2[3:0]);
  assign blank = (s2[3:0] == AN_BLANK);
  assign first = capture && sel.legal
              && (sel.idx == 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SYNC;
      want        <= 2'd0;
      frame       <= '0;
      bad         <= 1'b0;
      score       <= '0;
      score_valid <= 1'b0;
      frame_bad   <= 1'b0;
      order_err   <= 1'b0;
    end else begin
      score_valid <= 1'b0;
      order_err   <= 1'b0;
      unique case (state)
        SYNC, PUBLISH: begin
          if (state == PUBLISH) begin
            score       <= frame;
            frame_bad   <= bad;
            score_valid <= 1'b1;
            state       <= SYNC;
          end
          if (first) begin
            frame <= {12'h000, nib};
            bad   <= ~seg_ok;
            want  <= 2'd1;
            state <= COLLECT;
          end
        end
        COLLECT: begin
          if (capture && !blank) begin
            if (sel.legal && sel.idx == want) begin
              frame[{want, 2'b00} +: 4] <= nib;
              bad <= bad | ~seg_ok;
              if (want == 2'd3)
                state <= PUBLISH;
              else
                want <= want + 2'd1;
            end else if (first) begin
              frame     <= {12'h000, nib};
              bad       <= ~seg_ok;
              want      <= 2'd1;
              order_err <= 1'b1;
            end else begin
              frame     <= '0;
              bad       <= 1'b0;
              want      <= 2'd0;
              order_err <= 1'b1;
              state     <= SYNC;
            end
          end
        end
        default: state <= SYNC;
      endcase
    end
  end

  assign bus.score       = score;
  assign bus.score_valid = score_valid;
  assign bus.frame_bad   = frame_bad;
  assign bus.order_err   = order_err;

endmodule

// File: tb/tb_ssled_capture.sv
// Scan-capture bench: directed frames plus random dwells against a
// dwell-list reference model.
module tb_ssled_capture;

  localparam int SETTLE = 4;
  localparam logic [6:0] PAT [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100,
    7'b0110000, 7'b0011001, 7'b0010010,
    7'b0000010, 7'b1111000, 7'b0000000,
    7'b0010000
  };

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ssled_if bus ();

  ssled_capture #(.SETTLE(SETTLE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total  = 0;
  int passed = 0;

  logic [16:0] exp_q[$];
  logic [16:0] got_q[$];
  int exp_err = 0;
  int got_err = 0;

  logic [6:0] cur_seg = 7'h7F;
  logic [3:0] cur_an  = 4'hF;
  int         cur_len = 0;
  bit         in_frame = 0;
  int         have = 0;
  logic [3:0] nibs [4];
  bit         fbad = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.score_valid)
        got_q.push_back({bus.frame_bad, bus.score});
      if (bus.order_err)
        got_err++;
    end
  end

  // Reference: one settled dwell is one capture, scored by frame rules.
  task automatic model_capture(
    input logic [6:0] s,
    input logic [3:0] a
  );
    int d;
    logic [3:0] n;
    bit b;
    logic [3:0] oh;
    if (a == 4'hF) return;
    d = -1;
    for (int k = 0; k < 4; k++) begin
      oh = ~(4'b0001 << k);
      if (a == oh) d = k;
    end
    n = 4'hF;
    b = 1;
    for (int v = 0; v < 10; v++)
      if (s == PAT[v]) begin
        n = 4'(v);
        b = 0;
      end
    if (!in_frame) begin
      if (d == 0) begin
        in_frame = 1; have = 1;
        nibs[0] = n; fbad = b;
      end
    end else if (d == have) begin
      nibs[d] = n;
      fbad = fbad | b;
      have++;
      if (have == 4) begin
        exp_q.push_back({fbad, nibs[3], nibs[2],
                         nibs[1], nibs[0]});
        in_frame = 0;
      end
    end else if (d == 0) begin
      exp_err++;
      have = 1; nibs[0] = n; fbad = b;
    end else begin
      exp_err++;
      in_frame = 0;
    end
  endtask

  task automatic dwell(
    input logic [6:0] s,
    input logic [3:0] a,
    input int len
  );
    if ({s, a} != {cur_seg, cur_an}) begin
      if (cur_len >= SETTLE)
        model_capture(cur_seg, cur_an);
      cur_seg = s; cur_an = a; cur_len = len;
    end else begin
      cur_len += len;
    end
    bus.seg = s;
    bus.an  = a;
    repeat (len) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [3:0] an_of(input int k);
    logic [3:0] one;
    one = 4'b0001 << k;
    return ~one;
  endfunction

  task automatic digit(input int k, input int v, input int len);
    dwell(PAT[v], an_of(k), len);
  endtask

  task automatic scan(input logic [15:0] val, input int len);
    for (int k = 0; k < 4; k++)
      digit(k, int'(val[4*k +: 4]), len);
  endtask

  task automatic drain();
    dwell(7'h7F, 4'hF, SETTLE + 8);
  endtask

  task automatic begin_test();
    drain();
    exp_q.delete();
    got_q.delete();
    exp_err = 0;
    got_err = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_frame = 0;
    cur_seg = 7'h7F; cur_an = 4'hF; cur_len = 0;
  endtask

  task automatic test_reset();
    bus.seg = 7'h7F;
    bus.an  = 4'hF;
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    total++;
    if (bus.score !== 16'h0)
      $display("FAIL rst_score: got %h want 0000", bus.score);
    else passed++;
    total++;
    if (bus.score_valid !== 1'b0)
      $display("FAIL rst_valid: got %b want 0", bus.score_valid);
    else passed++;
    total++;
    if (bus.frame_bad !== 1'b0)
      $display("FAIL rst_bad: got %b want 0", bus.frame_bad);
    else passed++;
    total++;
    if (bus.order_err !== 1'b0)
      $display("FAIL rst_err: got %b want 0", bus.order_err);
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_scan();
    begin_test();
    repeat (3) scan(16'h1234, 8);
    drain();
    total++;
    if (got_q.size() != exp_q.size() || got_q.size() != 3)
      $display("FAIL scan_count: got %0d want %0d",
               got_q.size(), exp_q.size());
    else passed++;
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= got_q.size())
        $display("FAIL scan_pub%0d: got none want %h", i, exp_q[i]);
      else if (got_q[i] !== exp_q[i])
        $display("FAIL scan_pub%0d: got %h want %h",
                 i, got_q[i], exp_q[i]);
      else passed++;
    end
    total++;
    if (got_err != 0)
      $display("FAIL scan_err: got %0d want 0", got_err);
    else passed++;
    total++;
    if ({bus.frame_bad, bus.score} !== 17'h01234)
      $display("FAIL scan_hold: got %h want 01234",
               {bus.frame_bad, bus.score});
    else passed++;
  endtask

  task automatic test_glitch();
    begin_test();
    digit(0, 4, 8);
    digit(1, 3, 8);
    digit(3, 9, 2);
    digit(2, 2, 8);
    digit(3, 1, 8);
    drain();
    total++;
    if (got_q.size() != 1 || exp_q.size() != 1)
      $display("FAIL glitch_count: got %0d want %0d",
               got_q.size(), exp_q.size());
    else if (got_q[0] !== exp_q[0] || got_q[0] !== 17'h01234)
      $display("FAIL glitch_pub: got %h want %h", got_q[0], exp_q[0]);
    else passed++;
    total++;
    if (got_err != exp_err || got_err != 0)
      $display("FAIL glitch_err: got %0d want %0d", got_err, exp_err);
    else passed++;
  endtask

  task automatic test_bad_seg();
    begin_test();
    digit(0, 4, 8);
    digit(1, 3, 8);
    dwell(7'h7F, an_of(2), 8);
    digit(3, 1, 8);
    drain();
    total++;
    if (got_q.size() != 1 || exp_q.size() != 1)
      $display("FAIL bad_count: got %0d want %0d",
               got_q.size(), exp_q.size());
    else if (got_q[0] !== exp_q[0] || got_q[0] !== 17'h11F34)
      $display("FAIL bad_pub: got %h want %h", got_q[0], exp_q[0]);
    else passed++;
    total++;
    if (got_err != exp_err)
      $display("FAIL bad_err: got %0d want %0d", got_err, exp_err);
    else passed++;
  endtask

  task automatic test_skip();
    begin_test();
    digit(0, 1, 8);
    digit(2, 2, 8);
    scan(16'h0567, 8);
    drain();
    total++;
    if (got_err != exp_err || got_err != 1)
      $display("FAIL skip_err: got %0d want %0d", got_err, exp_err);
    else passed++;
    total++;
    if (got_q.size() != 1 || exp_q.size() != 1)
      $display("FAIL skip_count: got %0d want %0d",
               got_q.size(), exp_q.size());
    else if (got_q[0] !== exp_q[0] || got_q[0] !== 17'h00567)
      $display("FAIL skip_pub: got %h want %h", got_q[0], exp_q[0]);
    else passed++;
  endtask

  task automatic test_midscan();
    begin_test();
    do_reset();
    digit(2, 3, 8);
    digit(3, 4, 8);
    scan(16'h4321, 8);
    drain();
    total++;
    if (got_err != 0)
      $display("FAIL mid_err: got %0d want 0", got_err);
    else passed++;
    total++;
    if (got_q.size() != 1 || exp_q.size() != 1)
      $display("FAIL mid_count: got %0d want %0d",
               got_q.size(), exp_q.size());
    else if (got_q[0] !== exp_q[0] || got_q[0] !== 17'h04321)
      $display("FAIL mid_pub: got %h want %h", got_q[0], exp_q[0]);
    else passed++;
  endtask

  task automatic test_rst_mid();
    begin_test();
    digit(0, 5, 8);
    digit(1, 5, 8);
    digit(2, 5, 8);
    dwell(7'h7F, 4'hF, 3);
    do_reset();
    total++;
    if ({bus.frame_bad, bus.score} !== 17'h0)
      $display("FAIL rstmid_out: got %h want 00000",
               {bus.frame_bad, bus.score});
    else passed++;
    total++;
    if (bus.score_valid !== 1'b0 || bus.order_err !== 1'b0)
      $display("FAIL rstmid_pulse: got %b%b want 00",
               bus.score_valid, bus.order_err);
    else passed++;
    digit(3, 5, 8);
    scan(16'h9876, 8);
    drain();
    total++;
    if (got_q.size() != 1 || exp_q.size() != 1)
      $display("FAIL rstmid_count: got %0d want %0d",
               got_q.size(), exp_q.size());
    else if (got_q[0] !== exp_q[0] || got_q[0] !== 17'h09876)
      $display("FAIL rstmid_pub: got %h want %h", got_q[0], exp_q[0]);
    else passed++;
    total++;
    if (got_err != 0)
      $display("FAIL rstmid_err: got %0d want 0", got_err);
    else passed++;
  endtask

  task automatic test_random();
    int pos;
    int r;
    begin_test();
    pos = 0;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 19);
      if (r == 0)
        dwell(7'($urandom), 4'($urandom), $urandom_range(1, 3));
      else if (r == 1)
        dwell(7'($urandom), 4'($urandom), $urandom_range(2, 9));
      else if (r == 2)
        dwell(7'($urandom), an_of($urandom_range(0, 3)),
              $urandom_range(4, 9));
      else if (r == 3)
        dwell(7'h7F, 4'hF, $urandom_range(1, 6));
      else begin
        if (r == 4) pos = (pos + 1) % 4;
        digit(pos, $urandom_range(0, 9), $urandom_range(3, 9));
        pos = (pos + 1) % 4;
      end
    end
    drain();
    total++;
    if (got_q.size() != exp_q.size())
      $display("FAIL rand_count: got %0d want %0d",
               got_q.size(), exp_q.size());
    else passed++;
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= got_q.size())
        $display("FAIL rand_pub%0d: got none want %h", i, exp_q[i]);
      else if (got_q[i] !== exp_q[i])
        $display("FAIL rand_pub%0d: got %h want %h",
                 i, got_q[i], exp_q[i]);
      else passed++;
    end
    total++;
    if (got_err != exp_err)
      $display("FAIL rand_err: got %0d want %0d", got_err, exp_err);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_glitch();
    test_bad_seg();
    test_skip();
    test_midscan();
    test_rst_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
